// File: rtl/spi_slave_responder.sv
// Purpose : SPI mode-0 register responder (0x0A write / 0x0B read, auto-increment) with a 64x8 register file.
// Latency : SCLK/CS edges acted on 3 clk after the pin edge; wr_strobe 4 clk after the 8th rise; miso 3-4 clk after a fall.
// Backpressure: none; the SPI master paces everything, and sample_valid is always accepted (held while a frame is open).
//
// Ports:
//   clk, rst_n                  system clock, async active-low reset
//   sclk, cs, mosi              SPI pins from master (asynchronous, oversampled)
//   miso                        SPI data to master, 0 whenever cs is high
//   sample_valid, sample_x/y/z  new X/Y/Z sample for registers 0x08..0x0A
//   wr_strobe, wr_addr, wr_data pulse + address/data of each accepted register write
//   frame_err                   pulse when cs rises in the middle of a byte
module spi_slave_responder #(
  parameter int unsigned ADDR_W = 6,
  parameter logic [7:0]  DEVID  = 8'hAD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic              sample_valid,
  input  logic [7:0]        sample_x,
  input  logic [7:0]        sample_y,
  input  logic [7:0]        sample_z,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_err
);

  localparam int                NREG     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] RO_LIMIT = ADDR_W'(11);
  localparam logic [ADDR_W-1:0] REG_X    = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] REG_Y    = ADDR_W'(9);
  localparam logic [ADDR_W-1:0] REG_Z    = ADDR_W'(10);
  localparam logic [7:0]        CMD_WR   = 8'h0A;
  localparam logic [7:0]        CMD_RD   = 8'h0B;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WR, S_RD, S_IGNORE} state_t;

  state_t r_state, w_state_nxt;
  logic   r_dir_wr, w_dir_wr_nxt;

  // Two-flop synchronizers; sclk and cs also keep a history flop for edge detection.
  // mosi only needs its level at the sclk rise, so it has no history flop.
  logic r_sclk_s1, r_sclk_s2, r_sclk_h;
  logic r_cs_s1, r_cs_s2, r_cs_h;
  logic r_mosi_s1, r_mosi_s2;

  logic [7:0]        r_rx_shift, r_tx_shift;
  logic [2:0]        r_bit_cnt;
  logic              r_byte_done;
  logic              r_rd_pend;
  logic [ADDR_W-1:0] r_addr_ptr;
  logic [7:0]        r_regs [NREG];

  logic              r_pend_vld;
  logic [7:0]        r_pend_x, r_pend_y, r_pend_z;

  logic              r_wr_strobe, r_frame_err;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;

  logic w_cs_act, w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
  logic w_wr_en, w_ptr_load, w_ptr_inc_wr, w_rd_arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_h <= 1'b0;
      r_cs_s1   <= 1'b1; r_cs_s2   <= 1'b1; r_cs_h   <= 1'b1;
      r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= sclk;  r_sclk_s2 <= r_sclk_s1; r_sclk_h <= r_sclk_s2;
      r_cs_s1   <= cs;    r_cs_s2   <= r_cs_s1;   r_cs_h   <= r_cs_s2;
      r_mosi_s1 <= mosi;  r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_cs_act    = ~r_cs_s2;
  assign w_cs_fall   = ~r_cs_s2 &  r_cs_h;
  assign w_cs_rise   =  r_cs_s2 & ~r_cs_h;
  // sclk activity outside a frame is ignored
  assign w_sclk_rise = w_cs_act &  r_sclk_s2 & ~r_sclk_h;
  assign w_sclk_fall = w_cs_act & ~r_sclk_s2 &  r_sclk_h;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_dir_wr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dir_wr <= w_dir_wr_nxt;
    end
  end

  // FSM next state; decisions are taken on the clk after a byte completes
  always_comb begin
    w_state_nxt  = r_state;
    w_dir_wr_nxt = r_dir_wr;
    w_wr_en      = 1'b0;
    w_ptr_load   = 1'b0;
    w_ptr_inc_wr = 1'b0;
    w_rd_arm     = 1'b0;
    if (w_cs_rise) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_cs_fall) w_state_nxt = S_CMD;
        S_CMD: begin
          if (r_byte_done) begin
            if (r_rx_shift == CMD_WR) begin
              w_state_nxt  = S_ADDR;
              w_dir_wr_nxt = 1'b1;
            end else if (r_rx_shift == CMD_RD) begin
              w_state_nxt  = S_ADDR;
              w_dir_wr_nxt = 1'b0;
            end else begin
              w_state_nxt  = S_IGNORE;
            end
          end
        end
        S_ADDR: begin
          if (r_byte_done) begin
            w_ptr_load = 1'b1;
            if (r_dir_wr) begin
              w_state_nxt = S_WR;
            end else begin
              w_state_nxt = S_RD;
              w_rd_arm    = 1'b1;
            end
          end
        end
        S_WR: begin
          if (r_byte_done) begin
            w_ptr_inc_wr = 1'b1;
            // identity and sample registers are read-only from SPI
            w_wr_en      = (r_addr_ptr >= RO_LIMIT);
          end
        end
        S_RD: if (r_byte_done) w_rd_arm = 1'b1;
        default: ;
      endcase
    end
  end

  // Bit engine, address pointer and write reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_shift  <= 8'h00;
      r_tx_shift  <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_byte_done <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_addr_ptr  <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'h00;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_done <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_strobe <= w_wr_en;
      if (w_wr_en) begin
        r_wr_addr <= r_addr_ptr;
        r_wr_data <= r_rx_shift;
      end
      if (w_cs_rise) begin
        r_bit_cnt   <= 3'd0;
        r_tx_shift  <= 8'h00;
        r_rd_pend   <= 1'b0;
        r_frame_err <= (r_bit_cnt != 3'd0);
      end else begin
        if (w_sclk_rise) begin
          r_rx_shift  <= {r_rx_shift[6:0], r_mosi_s2};
          r_bit_cnt   <= r_bit_cnt + 3'd1;   // wraps to 0 on the 8th bit
          r_byte_done <= (r_bit_cnt == 3'd7);
        end
        if (w_rd_arm) r_rd_pend <= 1'b1;
        // a read byte is loaded on the first fall after the previous byte completed,
        // so its MSB is on miso before the master's next sampling rise
        if (w_sclk_fall) begin
          if (r_rd_pend) begin
            r_tx_shift <= r_regs[r_addr_ptr];
            r_rd_pend  <= 1'b0;
          end else begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          end
        end
      end
      if (w_ptr_load) begin
        r_addr_ptr <= r_rx_shift[ADDR_W-1:0];
      end else if (w_ptr_inc_wr || (w_sclk_fall && r_rd_pend)) begin
        r_addr_ptr <= r_addr_ptr + ADDR_W'(1);
      end
    end
  end

  // Pending sample: held while a frame is open so a burst sees one coherent X/Y/Z set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_vld <= 1'b0;
      r_pend_x   <= 8'h00;
      r_pend_y   <= 8'h00;
      r_pend_z   <= 8'h00;
    end else if (r_cs_s2) begin
      r_pend_vld <= 1'b0;
    end else if (sample_valid) begin
      r_pend_vld <= 1'b1;
      r_pend_x   <= sample_x;
      r_pend_y   <= sample_y;
      r_pend_z   <= sample_z;
    end
  end

  // Register file; a fresh sample on the commit clk wins over the pending one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= (i == 0) ? DEVID : 8'h00;
    end else begin
      if (w_wr_en) r_regs[r_addr_ptr] <= r_rx_shift;
      if (r_cs_s2) begin
        if (sample_valid) begin
          r_regs[REG_X] <= sample_x;
          r_regs[REG_Y] <= sample_y;
          r_regs[REG_Z] <= sample_z;
        end else if (r_pend_vld) begin
          r_regs[REG_X] <= r_pend_x;
          r_regs[REG_Y] <= r_pend_y;
          r_regs[REG_Z] <= r_pend_z;
        end
      end
    end
  end

  assign miso      = r_tx_shift[7] & ~cs;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: directed protocol scenarios plus randomized frames,
// checked against a byte-level register-file model.
module tb_spi_slave_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_x = 8'h00, sample_y = 8'h00, sample_z = 8'h00;
  logic       miso, wr_strobe, frame_err;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  spi_slave_responder #(.ADDR_W(6), .DEVID(8'hAD)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .sample_valid(sample_valid), .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor: records every write strobe with its latency from the latest sclk rise
  logic [13:0] got_wr  [256];
  int          got_lat [256];
  int          got_n = 0;
  int          ferr_cnt = 0;
  int          last_rise_cyc = 0;
  always @(negedge clk) begin
    if (wr_strobe && got_n < 256) begin
      got_wr[got_n]  = {wr_addr, wr_data};
      got_lat[got_n] = cyc - last_rise_cyc;
      got_n++;
    end
    if (frame_err) ferr_cnt++;
  end

  // Reference model state
  logic [7:0] m_regs [64];
  logic       m_pend_vld;
  logic [7:0] m_pend [3];

  logic [7:0] tx_b [8];
  logic [7:0] rx_b [8];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
    m_regs[0]  = 8'hAD;
    m_pend_vld = 1'b0;
  endtask

  task automatic put_sample(input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] sz);
    @(negedge clk);
    sample_x = sx; sample_y = sy; sample_z = sz; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    m_regs[8] = sx; m_regs[9] = sy; m_regs[10] = sz;
  endtask

  task automatic spi_byte(input logic [7:0] v, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      mosi = v[7-k];
      repeat (10) @(negedge clk);
      sclk = 1'b1;
      r[7-k] = miso;
      last_rise_cyc = cyc;
      repeat (10) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  // One cs-framed transfer of nb full bytes plus an optional partial byte of 'tail' bits.
  // A sample is delivered just before byte 'samp_at' when that byte exists.
  task automatic run_frame(input int nb, input int tail, input int samp_at,
                           input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] sz);
    int          w0, f0, nexp, a, addr, ntot;
    logic [7:0]  exp_rx [8];
    logic [13:0] exp_w  [8];
    w0 = got_n; f0 = ferr_cnt; nexp = 0;
    ntot = nb + ((tail > 0) ? 1 : 0);
    a = int'(tx_b[1][5:0]);
    for (int b = 0; b < nb; b++) begin
      exp_rx[b] = 8'h00;
      if (b >= 2) begin
        addr = (a + b - 2) % 64;
        if (tx_b[0] == 8'h0B) begin
          exp_rx[b] = m_regs[addr];
        end else if (tx_b[0] == 8'h0A && addr >= 11) begin
          m_regs[addr] = tx_b[b];
          exp_w[nexp]  = {6'(addr), tx_b[b]};
          nexp++;
        end
      end
    end
    @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int b = 0; b < ntot; b++) begin
      if (b == samp_at) begin
        sample_x = sx; sample_y = sy; sample_z = sz; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        m_pend_vld = 1'b1;
        m_pend[0] = sx; m_pend[1] = sy; m_pend[2] = sz;
      end
      spi_byte(tx_b[b], (b < nb) ? 8 : tail, rx_b[b]);
    end
    repeat (10) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    if (m_pend_vld) begin
      m_regs[8] = m_pend[0]; m_regs[9] = m_pend[1]; m_regs[10] = m_pend[2];
      m_pend_vld = 1'b0;
    end
    for (int b = 0; b < nb; b++) check($sformatf("miso_byte%0d", b), 32'(rx_b[b]), 32'(exp_rx[b]));
    check("wr_count", 32'(got_n - w0), 32'(nexp));
    for (int i = 0; i < nexp && (w0 + i) < got_n; i++) begin
      check("wr_addr_data", 32'(got_wr[w0+i]), 32'(exp_w[i]));
      check("wr_latency", 32'(got_lat[w0+i]), 32'd4);
    end
    check("frame_err_count", 32'(ferr_cnt - f0), (tail > 0) ? 32'd1 : 32'd0);
    check("miso_idle", 32'(miso), 32'd0);
  endtask

  initial begin
    int         op, nb, tail, sa, w0;
    logic [7:0] r;

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // DEVID read
    tx_b[0] = 8'h0B; tx_b[1] = 8'h00; tx_b[2] = 8'hFF;
    run_frame(3, 0, 99, 8'h0, 8'h0, 8'h0);
    check("devid", 32'(rx_b[2]), 32'hAD);

    // Burst write then read back
    tx_b[0] = 8'h0A; tx_b[1] = 8'h2D; tx_b[2] = 8'h02; tx_b[3] = 8'h52;
    run_frame(4, 0, 99, 8'h0, 8'h0, 8'h0);
    tx_b[0] = 8'h0B; tx_b[1] = 8'h2D; tx_b[2] = 8'h00; tx_b[3] = 8'h00;
    run_frame(4, 0, 99, 8'h0, 8'h0, 8'h0);
    check("burst_rd_2d", 32'(rx_b[2]), 32'h02);
    check("burst_rd_2e", 32'(rx_b[3]), 32'h52);

    // Coherent sample: new sample mid-burst only shows up in the next burst
    put_sample(8'h11, 8'h22, 8'h33);
    tx_b[0] = 8'h0B; tx_b[1] = 8'h08; tx_b[2] = 8'h00; tx_b[3] = 8'h00; tx_b[4] = 8'h00;
    run_frame(5, 0, 3, 8'h44, 8'h55, 8'h66);
    check("coh_x_old", 32'(rx_b[2]), 32'h11);
    run_frame(5, 0, 99, 8'h0, 8'h0, 8'h0);
    check("coh_x_new", 32'(rx_b[2]), 32'h44);
    check("coh_z_new", 32'(rx_b[4]), 32'h66);

    // Read-only protection, then wrap from 0x3F to 0x00
    tx_b[0] = 8'h0A; tx_b[1] = 8'h08; tx_b[2] = 8'h07;
    run_frame(3, 0, 99, 8'h0, 8'h0, 8'h0);
    tx_b[0] = 8'h0B; tx_b[1] = 8'h08; tx_b[2] = 8'h00;
    run_frame(3, 0, 99, 8'h0, 8'h0, 8'h0);
    check("ro_protect", 32'(rx_b[2]), 32'h44);
    tx_b[0] = 8'h0A; tx_b[1] = 8'h3F; tx_b[2] = 8'h5A;
    run_frame(3, 0, 99, 8'h0, 8'h0, 8'h0);
    tx_b[0] = 8'h0B; tx_b[1] = 8'h3F; tx_b[2] = 8'h00; tx_b[3] = 8'h00;
    run_frame(4, 0, 99, 8'h0, 8'h0, 8'h0);
    check("wrap_3f", 32'(rx_b[2]), 32'h5A);
    check("wrap_00", 32'(rx_b[3]), 32'hAD);

    // Bad command
    tx_b[0] = 8'h55; tx_b[1] = 8'h2D; tx_b[2] = 8'hFF; tx_b[3] = 8'hFF;
    run_frame(4, 0, 99, 8'h0, 8'h0, 8'h0);

    // Abort after 5 bits of a data byte, then a clean frame
    tx_b[0] = 8'h0A; tx_b[1] = 8'h30; tx_b[2] = 8'hA5;
    run_frame(2, 5, 99, 8'h0, 8'h0, 8'h0);
    tx_b[2] = 8'h77;
    run_frame(3, 0, 99, 8'h0, 8'h0, 8'h0);
    tx_b[0] = 8'h0B; tx_b[1] = 8'h30; tx_b[2] = 8'h00;
    run_frame(3, 0, 99, 8'h0, 8'h0, 8'h0);

    // Randomized frames
    for (int it = 0; it < 25; it++) begin
      op = $urandom_range(0, 4);
      tail = 0;
      sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : 99;
      for (int b = 1; b < 8; b++) tx_b[b] = 8'($urandom_range(0, 255));
      case (op)
        0: begin tx_b[0] = 8'h0A; nb = $urandom_range(3, 5); end
        1: begin tx_b[0] = 8'h0B; nb = $urandom_range(3, 5); end
        2: begin
          tx_b[0] = 8'($urandom_range(0, 253));
          if (tx_b[0] >= 8'h0A) tx_b[0] = tx_b[0] + 8'd2;
          nb = $urandom_range(1, 4);
        end
        3: begin
          put_sample(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
          tx_b[0] = 8'h0B; tx_b[1] = 8'h08; nb = 5;
        end
        default: begin tx_b[0] = 8'h0A; nb = $urandom_range(2, 3); tail = $urandom_range(1, 7); end
      endcase
      run_frame(nb, tail, sa, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    // Asynchronous reset in the middle of a write burst
    w0 = got_n;
    @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    spi_byte(8'h0A, 8, r);
    spi_byte(8'h2D, 8, r);
    spi_byte(8'h99, 8, r);
    spi_byte(8'hC3, 3, r);
    check("pre_rst_wr_count", 32'(got_n - w0), 32'd1);
    check("pre_rst_wr", 32'(got_wr[w0]), 32'h2D99);
    #3 rst_n = 1'b0;
    #1;
    check("arst_miso", 32'(miso), 32'd0);
    check("arst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("arst_wr_addr", 32'(wr_addr), 32'd0);
    check("arst_wr_data", 32'(wr_data), 32'd0);
    check("arst_frame_err", 32'(frame_err), 32'd0);
    sclk = 1'b0;
    cs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    tx_b[0] = 8'h0B; tx_b[1] = 8'h2D; tx_b[2] = 8'h00;
    run_frame(3, 0, 99, 8'h0, 8'h0, 8'h0);
    check("post_rst_2d", 32'(rx_b[2]), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: observed no completion expected finish before 150000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
